// File: rtl/ps2_pkg.sv
// Shared register offsets, status/control bit positions and types for the PS/2 controller.
package ps2_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_ERR      = 1;
  localparam int STAT_TX_BUSY  = 2;
  localparam int STAT_OVF      = 3;
  localparam int STAT_IE       = 4;

  localparam int CTRL_IE    = 0;
  localparam int CTRL_FLUSH = 1;

  // Field order matches the STAT_* positions above (rx_valid is bit 0).
  typedef struct packed {
    logic [2:0] rsvd;
    logic       ie;
    logic       ovf;
    logic       tx_busy;
    logic       err;
    logic       rx_valid;
  } ps2_stat_t;

  typedef enum logic [1:0] {H_IDLE, H_RX, H_INHIBIT, H_TX} ps2_host_e;

endpackage

// File: rtl/ps2_multi_controller_if.sv
// CPU data-bus port of the PS/2 controller: master drives the access, slave acks with read data.
interface ps2_multi_controller_if;
  logic        cs;
  logic        data_m_access;
  logic        data_m_wr_en;
  logic [2:0]  data_m_addr;
  logic [15:0] data_m_data_in;
  logic [1:0]  data_m_bytesel;
  logic        data_m_ack;
  logic [15:0] data_m_data_out;

  modport master (
    output cs, data_m_access, data_m_wr_en, data_m_addr, data_m_data_in, data_m_bytesel,
    input  data_m_ack, data_m_data_out
  );

  modport slave (
    input  cs, data_m_access, data_m_wr_en, data_m_addr, data_m_data_in, data_m_bytesel,
    output data_m_ack, data_m_data_out
  );
endinterface

// File: rtl/ps2_channel.sv
// One PS/2 port: host framing (RX/TX), RX FIFO with flush, error/overflow/ie flags, interrupt.
// PS2_IRQ_MASK_EN defined: ie is a writable register; undefined: ie is tied to 1.
module ps2_channel
  import ps2_pkg::*;
#(
  parameter int clkf       = 50000000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_we_i,
  input  logic [7:0] tx_data_i,
  input  logic       pop_i,
  input  logic       ctrl_we_i,
  input  logic [1:0] ctrl_i,
  input  logic       rd_clr_i,
  output logic [7:0] head_o,
  output ps2_stat_t  stat_o,
  output logic       intr_o,
  inout  wire        ps2_clk,
  inout  wire        ps2_dat
);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int INHIBIT = (clkf / 10000 > 2) ? clkf / 10000 : 2;  // 100 us clock hold
  localparam int CW      = $clog2(INHIBIT);

  ps2_host_e     st_q;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic [3:0]    bit_q;
  logic [8:0]    rx_sh_q;
  logic [9:0]    tx_sh_q;
  logic [CW-1:0] cnt_q;
  logic          clk_oe_q, dat_oe_q, tx_busy_q, rx_valid_q, rx_err_q;
  logic [7:0]    rx_byte_q;
  logic          fall;
  logic [9:0]    rx_frame;

  assign ps2_clk  = clk_oe_q ? 1'b0 : 1'bz;
  assign ps2_dat  = dat_oe_q ? 1'b0 : 1'bz;
  assign fall     = clk_prev_q & ~clk_sync_q[1];
  assign rx_frame = {dat_sync_q[1], rx_sh_q};  // {stop, parity, data[7:0]}

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= H_IDLE;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      bit_q      <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      cnt_q      <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      clk_prev_q <= clk_sync_q[1];
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (tx_we_i && !tx_busy_q) begin
        tx_busy_q <= 1'b1;
        tx_sh_q   <= {1'b1, ~^tx_data_i, tx_data_i};
      end
      case (st_q)
        H_IDLE: begin
          if (tx_busy_q) begin
            st_q     <= H_INHIBIT;
            clk_oe_q <= 1'b1;
            cnt_q    <= '0;
          end else if (fall && !dat_sync_q[1]) begin
            st_q  <= H_RX;
            bit_q <= '0;
          end
        end
        H_RX: begin
          if (fall) begin
            rx_sh_q <= {dat_sync_q[1], rx_sh_q[8:1]};
            bit_q   <= bit_q + 4'd1;
            if (bit_q == 4'd9) begin
              st_q      <= H_IDLE;
              rx_byte_q <= rx_frame[7:0];
              if (rx_frame[9] && (^rx_frame[8:0])) rx_valid_q <= 1'b1;
              else                                  rx_err_q   <= 1'b1;
            end
          end
        end
        H_INHIBIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(INHIBIT - 1)) begin
            st_q     <= H_TX;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b1;  // start bit
            bit_q    <= '0;
          end
        end
        default: begin  // H_TX: data changes on device falling edges; 11th edge is the ack
          if (fall) begin
            if (bit_q == 4'd10) begin
              st_q      <= H_IDLE;
              tx_busy_q <= 1'b0;
              dat_oe_q  <= 1'b0;
            end else begin
              dat_oe_q <= ~tx_sh_q[0];
              tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
              bit_q    <= bit_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        empty, full, flush, do_pop, do_push, ovf_q, err_q, ie;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign flush   = ctrl_we_i & ctrl_i[CTRL_FLUSH];
  assign do_pop  = pop_i & ~empty;
  assign do_push = rx_valid_q & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= rx_byte_q;
  end

  // Flag set beats a same-cycle clear, including a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (do_push) wr_q <= wr_q + 1'b1;
        if (do_pop)  rd_q <= rd_q + 1'b1;
      end
      if (rx_valid_q && full && !do_pop) ovf_q <= 1'b1;
      else if (rd_clr_i || flush)        ovf_q <= 1'b0;
      if (rx_err_q)      err_q <= 1'b1;
      else if (rd_clr_i) err_q <= 1'b0;
    end
  end

`ifdef PS2_IRQ_MASK_EN
  logic ie_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ie_q <= 1'b0;
    else if (ctrl_we_i) ie_q <= ctrl_i[CTRL_IE];
  end
  assign ie = ie_q;
`else
  logic unused_ie_bit;
  assign unused_ie_bit = ctrl_i[CTRL_IE];
  assign ie = 1'b1;
`endif

  assign head_o = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign stat_o = '{rsvd: 3'b000, ie: ie, ovf: ovf_q, tx_busy: tx_busy_q, err: err_q, rx_valid: ~empty};
  assign intr_o = ie & ~empty;

endmodule

// File: rtl/ps2_multi_controller.sv
// Multi-channel PS/2 host: register decode, read mux and one-cycle ack over per-channel ps2_channel.
// PS2_IRQ_MASK_EN selects a writable interrupt enable inside each channel.
module ps2_multi_controller
  import ps2_pkg::*;
#(
  parameter int clkf         = 50000000,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  ps2_multi_controller_if.slave    bus,
  output logic [NUM_CHANNELS-1:0]  ps2_intr,
  inout  wire  [NUM_CHANNELS-1:0]  ps2_clk,
  inout  wire  [NUM_CHANNELS-1:0]  ps2_dat
);
  logic                         acc, wr, rd, reg_sel;
  logic [1:0]                   ch;
  logic [NUM_CHANNELS-1:0][7:0] head;
  ps2_stat_t                    stat [NUM_CHANNELS];
  logic                         ack_q;
  logic [15:0]                  rdata_q, rdata_d;
  logic                         unused_din;

  assign acc        = bus.cs & bus.data_m_access;
  assign wr         = acc & bus.data_m_wr_en;
  assign rd         = acc & ~bus.data_m_wr_en;
  assign ch         = bus.data_m_addr[2:1];
  assign reg_sel    = bus.data_m_addr[0];
  assign unused_din = ^bus.data_m_data_in[15:8];

  // Out-of-range channel indices match no instance, so they are acked but inert.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic sel;
    assign sel = (ch == 2'(g));
    ps2_channel #(.clkf(clkf), .FIFO_DEPTH(FIFO_DEPTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tx_we_i  (sel & wr & (reg_sel == REG_DATA) & bus.data_m_bytesel[0]),
      .tx_data_i(bus.data_m_data_in[7:0]),
      .pop_i    (sel & wr & (reg_sel == REG_DATA) & bus.data_m_bytesel[1]),
      .ctrl_we_i(sel & wr & (reg_sel == REG_CTRL) & bus.data_m_bytesel[0]),
      .ctrl_i   (bus.data_m_data_in[1:0]),
      .rd_clr_i (sel & rd & (reg_sel == REG_DATA) & bus.data_m_bytesel[1]),
      .head_o   (head[g]),
      .stat_o   (stat[g]),
      .intr_o   (ps2_intr[g]),
      .ps2_clk  (ps2_clk[g]),
      .ps2_dat  (ps2_dat[g])
    );
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd && ch == 2'(i))
        rdata_d = (reg_sel == REG_CTRL) ? {15'b0, stat[i].ie} : {stat[i], head[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= acc;
      rdata_q <= rdata_d;
    end
  end

  assign bus.data_m_ack      = ack_q;
  assign bus.data_m_data_out = rdata_q;

endmodule

// File: tb/tb_ps2_multi_controller.sv
// Directed bench for ps2_multi_controller with behavioural PS/2 devices on two channels.
module tb_ps2_multi_controller;
  localparam int HALF = 20;
`ifdef PS2_IRQ_MASK_EN
  localparam logic IEDEF = 1'b0;
`else
  localparam logic IEDEF = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  ps2_multi_controller_if bus();
  logic [1:0] ps2_intr;
  wire  [1:0] ps2_clk, ps2_dat;
  logic [1:0] dclk_low, ddat_low;
  int total = 0, bad = 0;

  for (genvar i = 0; i < 2; i++) begin : g_dev
    assign ps2_clk[i] = dclk_low[i] ? 1'b0 : 1'bz;
    assign ps2_dat[i] = ddat_low[i] ? 1'b0 : 1'bz;
    pullup pu_c (ps2_clk[i]);
    pullup pu_d (ps2_dat[i]);
  end

  ps2_multi_controller #(.clkf(50000000), .NUM_CHANNELS(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .ps2_intr(ps2_intr), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat)
  );

  task automatic bus_xfer(input logic wr, input logic [2:0] a, input logic [15:0] d,
                          input logic [1:0] bs, output logic ack, output logic [15:0] q);
    @(negedge clk);
    bus.cs = 1'b1; bus.data_m_access = 1'b1; bus.data_m_wr_en = wr;
    bus.data_m_addr = a; bus.data_m_data_in = d; bus.data_m_bytesel = bs;
    @(negedge clk);
    bus.cs = 1'b0; bus.data_m_access = 1'b0; bus.data_m_wr_en = 1'b0;
    ack = bus.data_m_ack;
    q   = bus.data_m_data_out;
  endtask

  task automatic dev_send(input int ch, input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ddat_low[ch] = ~f[i];
      repeat (HALF) @(posedge clk);
      dclk_low[ch] = 1'b1;
      repeat (HALF) @(posedge clk);
      dclk_low[ch] = 1'b0;
    end
    ddat_low[ch] = 1'b0;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic dev_recv(input int ch, output logic [7:0] b, output logic ok);
    int n;
    logic [9:0] f;
    ok = 1'b1; b = 8'h00; f = '0;
    n = 0;
    while (ps2_clk[ch] !== 1'b0 && n < 20000) begin @(posedge clk); n++; end
    if (n >= 20000) ok = 1'b0;
    n = 0;
    while (!(ps2_clk[ch] === 1'b1 && ps2_dat[ch] === 1'b0) && n < 20000) begin @(posedge clk); n++; end
    if (n >= 20000) ok = 1'b0;
    if (ok) begin
      for (int i = 0; i < 11; i++) begin
        if (i == 10) ddat_low[ch] = 1'b1;
        repeat (HALF) @(posedge clk);
        dclk_low[ch] = 1'b1;
        repeat (HALF) @(posedge clk);
        dclk_low[ch] = 1'b0;
        if (i < 10) f[i] = ps2_dat[ch];
      end
      ddat_low[ch] = 1'b0;
      b  = f[7:0];
      ok = f[9] & (^f[8:0]);
    end
  endtask

  task automatic test_reset();
    logic a; logic [15:0] q;
    total++; if (ps2_intr !== 2'b00) begin bad++; $display("FAIL rst_intr got=%b exp=00", ps2_intr); end
    total++; if (bus.data_m_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", bus.data_m_ack); end
    total++; if (bus.data_m_data_out !== 16'h0) begin bad++; $display("FAIL rst_dout got=%h exp=0000", bus.data_m_data_out); end
    total++; if (ps2_clk !== 2'b11 || ps2_dat !== 2'b11) begin bad++; $display("FAIL rst_lines got=%b%b exp=1111", ps2_clk, ps2_dat); end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b00, a, q);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b exp=1", a); end
    total++; if (q !== {3'b0, IEDEF, 12'h000}) begin bad++; $display("FAIL rd_ch0 got=%h exp=%h", q, {3'b0, IEDEF, 12'h000}); end
    @(negedge clk);
    total++; if (bus.data_m_ack !== 1'b0 || bus.data_m_data_out !== 16'h0) begin
      bad++; $display("FAIL ack_drop got=%b/%h exp=0/0000", bus.data_m_ack, bus.data_m_data_out); end
  endtask

  task automatic test_ie_intr();
    logic unused_ack; logic [15:0] q;
    bus_xfer(1'b1, 3'd3, 16'h0001, 2'b01, unused_ack, q);
    dev_send(1, 8'h1C, 1'b0);
    @(negedge clk);
    total++; if (ps2_intr !== 2'b10) begin bad++; $display("FAIL intr_ch1 got=%b exp=10", ps2_intr); end
    bus_xfer(1'b0, 3'd2, 16'h0, 2'b00, unused_ack, q);
    total++; if (q !== 16'h111C) begin bad++; $display("FAIL rd_1c got=%h exp=111c", q); end
    bus_xfer(1'b1, 3'd2, 16'h0, 2'b10, unused_ack, q);
    @(negedge clk);
    total++; if (ps2_intr !== 2'b00) begin bad++; $display("FAIL intr_pop got=%b exp=00", ps2_intr); end
    bus_xfer(1'b0, 3'd2, 16'h0, 2'b00, unused_ack, q);
    total++; if (q !== 16'h1000) begin bad++; $display("FAIL rd_after_pop got=%h exp=1000", q); end
  endtask

  task automatic test_overflow();
    logic unused_ack; logic [15:0] q;
    for (int i = 1; i <= 9; i++) dev_send(0, 8'(i), 1'b0);
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b10, unused_ack, q);
    total++; if (q !== {3'b0, IEDEF, 4'b1001, 8'h01}) begin bad++; $display("FAIL ovf_stat got=%h exp=%h", q, {3'b0, IEDEF, 4'b1001, 8'h01}); end
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b00, unused_ack, q);
    total++; if (q !== {3'b0, IEDEF, 4'b0001, 8'h01}) begin bad++; $display("FAIL ovf_clr got=%h exp=%h", q, {3'b0, IEDEF, 4'b0001, 8'h01}); end
    for (int i = 1; i <= 8; i++) begin
      bus_xfer(1'b0, 3'd0, 16'h0, 2'b00, unused_ack, q);
      total++; if (q[7:0] !== 8'(i)) begin bad++; $display("FAIL fifo_order got=%h exp=%h", q[7:0], 8'(i)); end
      bus_xfer(1'b1, 3'd0, 16'h0, 2'b10, unused_ack, q);
    end
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b00, unused_ack, q);
    total++; if (q !== {3'b0, IEDEF, 12'h000}) begin bad++; $display("FAIL ovf_drained got=%h exp=%h", q, {3'b0, IEDEF, 12'h000}); end
  endtask

  task automatic test_parity();
    logic unused_ack; logic [15:0] q;
    dev_send(0, 8'h33, 1'b1);
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b10, unused_ack, q);
    total++; if (q !== {3'b0, IEDEF, 4'b0010, 8'h00}) begin bad++; $display("FAIL par_err got=%h exp=%h", q, {3'b0, IEDEF, 4'b0010, 8'h00}); end
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b00, unused_ack, q);
    total++; if (q !== {3'b0, IEDEF, 12'h000}) begin bad++; $display("FAIL par_clr got=%h exp=%h", q, {3'b0, IEDEF, 12'h000}); end
  endtask

  task automatic test_tx();
    logic unused_ack; logic [15:0] q; logic [7:0] b; logic ok;
    bus_xfer(1'b1, 3'd2, 16'h00ED, 2'b01, unused_ack, q);
    bus_xfer(1'b0, 3'd2, 16'h0, 2'b00, unused_ack, q);
    total++; if (q !== 16'h1400) begin bad++; $display("FAIL tx_busy got=%h exp=1400", q); end
    bus_xfer(1'b1, 3'd2, 16'h0055, 2'b01, unused_ack, q);
    fork
      dev_recv(1, b, ok);
      dev_send(0, 8'hA5, 1'b0);
    join
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL tx_frame got=%b exp=1", ok); end
    total++; if (b !== 8'hED) begin bad++; $display("FAIL tx_byte got=%h exp=ed", b); end
    bus_xfer(1'b0, 3'd2, 16'h0, 2'b00, unused_ack, q);
    total++; if (q !== 16'h1000) begin bad++; $display("FAIL tx_idle got=%h exp=1000", q); end
    repeat (200) @(negedge clk);
    total++; if (ps2_clk[1] !== 1'b1) begin bad++; $display("FAIL tx_second got=%b exp=1", ps2_clk[1]); end
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b00, unused_ack, q);
    total++; if (q !== {3'b0, IEDEF, 4'b0001, 8'hA5}) begin bad++; $display("FAIL rx_during_tx got=%h exp=%h", q, {3'b0, IEDEF, 4'b0001, 8'hA5}); end
    bus_xfer(1'b1, 3'd0, 16'h0, 2'b10, unused_ack, q);
  endtask

  task automatic test_flush();
    logic a; logic [15:0] q;
    dev_send(0, 8'h11, 1'b0);
    dev_send(0, 8'h22, 1'b0);
    dev_send(0, 8'h33, 1'b0);
    @(negedge clk);
    total++; if (ps2_intr !== {1'b0, IEDEF}) begin bad++; $display("FAIL intr_default got=%b exp=%b", ps2_intr, {1'b0, IEDEF}); end
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b00, a, q);
    total++; if (q !== {3'b0, IEDEF, 4'b0001, 8'h11}) begin bad++; $display("FAIL pre_flush got=%h exp=%h", q, {3'b0, IEDEF, 4'b0001, 8'h11}); end
    bus_xfer(1'b1, 3'd1, 16'h0003, 2'b01, a, q);
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b00, a, q);
    total++; if (q !== 16'h1000) begin bad++; $display("FAIL post_flush got=%h exp=1000", q); end
    total++; if (ps2_intr !== 2'b00) begin bad++; $display("FAIL intr_flush got=%b exp=00", ps2_intr); end
    bus_xfer(1'b0, 3'd1, 16'h0, 2'b00, a, q);
    total++; if (q !== 16'h0001) begin bad++; $display("FAIL ctrl_rd got=%h exp=0001", q); end
    bus_xfer(1'b0, 3'd4, 16'h0, 2'b00, a, q);
    total++; if (a !== 1'b1 || q !== 16'h0000) begin bad++; $display("FAIL oob_rd got=%b/%h exp=1/0000", a, q); end
    bus_xfer(1'b1, 3'd4, 16'h00FF, 2'b11, a, q);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL oob_wr_ack got=%b exp=1", a); end
    bus_xfer(1'b0, 3'd0, 16'h0, 2'b00, a, q);
    total++; if (q !== 16'h1000) begin bad++; $display("FAIL oob_wr_inert got=%h exp=1000", q); end
  endtask

  initial begin
    reset = 1'b1;
    bus.cs = 1'b0; bus.data_m_access = 1'b0; bus.data_m_wr_en = 1'b0;
    bus.data_m_addr = '0; bus.data_m_data_in = '0; bus.data_m_bytesel = '0;
    dclk_low = 2'b00; ddat_low = 2'b00;
    repeat (5) @(negedge clk);
    test_reset();
    test_ie_intr();
    test_overflow();
    test_parity();
    test_tx();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
